adex_param_loader_tx: RTL

// - Host-side transmitter for the AdEx neuron's nibble-serial parameter-load protocol.
// - Holds an 8-entry shadow copy of the neuron parameters (DeltaT, TauW, a, b, Vreset, VT, Ibias, C).
// - On start, streams all 8 bytes as hi/lo nibble pairs onto the neuron's ui_in[4:3] / uio_in[3:0] pins.
// - Mirrors the neuron's internal param_index so every byte lands at the intended slot.

---
 rtl/adex_param_loader_tx.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/adex_param_loader_tx.sv
`default_nettype none
// ============================================================================
// Module   : adex_param_loader_tx
// Brief    : Host-side nibble-serial parameter-load transmitter for the AdEx
//            neuron. Holds an 8-byte shadow of the neuron parameters and
//            streams them as HI/LO nibble pairs with optional idle gaps.
//            Optional feature macro: LOADER_STEP_GATE_EN (blocks step_en
//            while a load is in progress).
// Revision : 1.0 - initial release
// ============================================================================
module adex_param_loader_tx #(
    parameter int GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       start,
    input  logic       step_req,
    output logic       busy,
    output logic       done,
    output logic [1:0] ld_ctrl,
    output logic [3:0] ld_nibble,
    output logic       step_en,
    output logic [2:0] rx_ptr
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HI   = 3'd1,
        S_LO   = 3'd2,
        S_GAP  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [3:0] C_GAP_LAST  = 4'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
    localparam logic [3:0] C_NUM_BYTES = 4'd8;
    localparam logic [7:0] C_SHADOW_INIT [8] = '{
        8'h82, 8'h01, 8'h02, 8'h05, 8'h80, 8'h80, 8'hC8, 8'h01
    };

    state_t     r_state;
    logic [7:0] r_shadow [8];
    logic [7:0] r_tx_byte;
    logic [3:0] r_byte_cnt;
    logic [3:0] r_gap_cnt;

    logic       w_busy_next;
    logic [2:0] w_cap_idx;
    logic [7:0] w_cap_byte;

    // A LO->HI hop (no gap) captures before rx_ptr has advanced, so look one ahead.
    assign w_cap_idx  = (r_state == S_LO) ? (rx_ptr + 3'd1) : rx_ptr;
    assign w_cap_byte = r_shadow[w_cap_idx];

    always_comb begin
        w_busy_next = 1'b0;
        case (r_state)
            S_IDLE:  w_busy_next = start;
            S_HI:    w_busy_next = 1'b1;
            S_LO:    w_busy_next = (GAP_CYCLES != 0) || (r_byte_cnt != 4'd7);
            S_GAP:   w_busy_next = !((r_gap_cnt == C_GAP_LAST) && (r_byte_cnt == C_NUM_BYTES));
            default: w_busy_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_tx_byte  <= 8'h00;
            r_byte_cnt <= 4'd0;
            r_gap_cnt  <= 4'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            ld_ctrl    <= 2'b00;
            ld_nibble  <= 4'h0;
            step_en    <= 1'b0;
            rx_ptr     <= 3'd0;
            for (int i = 0; i < 8; i++) begin
                r_shadow[i] <= C_SHADOW_INIT[i];
            end
        end else begin
            if (wr_en) begin
                r_shadow[wr_addr] <= wr_data;
            end

            busy <= w_busy_next;
            done <= 1'b0;
`ifdef LOADER_STEP_GATE_EN
            step_en <= step_req & ~w_busy_next;
`else
            step_en <= step_req;
`endif

            case (r_state)
                S_IDLE: begin
                    ld_ctrl   <= 2'b00;
                    ld_nibble <= 4'h0;
                    if (start) begin
                        r_state    <= S_HI;
                        r_byte_cnt <= 4'd0;
                        r_tx_byte  <= w_cap_byte;
                        ld_ctrl    <= 2'b11;
                        ld_nibble  <= w_cap_byte[7:4];
                    end
                end
                S_HI: begin
                    r_state   <= S_LO;
                    ld_ctrl   <= 2'b00;
                    ld_nibble <= r_tx_byte[3:0];
                end
                S_LO: begin
                    rx_ptr     <= rx_ptr + 3'd1;
                    r_byte_cnt <= r_byte_cnt + 4'd1;
                    ld_ctrl    <= 2'b00;
                    ld_nibble  <= 4'h0;
                    if (GAP_CYCLES != 0) begin
                        r_state   <= S_GAP;
                        r_gap_cnt <= 4'd0;
                    end else if (r_byte_cnt == 4'd7) begin
                        r_state <= S_DONE;
                        done    <= 1'b1;
                    end else begin
                        r_state   <= S_HI;
                        r_tx_byte <= w_cap_byte;
                        ld_ctrl   <= 2'b11;
                        ld_nibble <= w_cap_byte[7:4];
                    end
                end
                S_GAP: begin
                    ld_ctrl   <= 2'b00;
                    ld_nibble <= 4'h0;
                    if (r_gap_cnt == C_GAP_LAST) begin
                        if (r_byte_cnt == C_NUM_BYTES) begin
                            r_state <= S_DONE;
                            done    <= 1'b1;
                        end else begin
                            r_state   <= S_HI;
                            r_tx_byte <= w_cap_byte;
                            ld_ctrl   <= 2'b11;
                            ld_nibble <= w_cap_byte[7:4];
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 4'd1;
                    end
                end
                S_DONE: begin
                    // start is deliberately ignored here; a new load needs an IDLE cycle.
                    r_state   <= S_IDLE;
                    ld_ctrl   <= 2'b00;
                    ld_nibble <= 4'h0;
                end
                default: begin
                    r_state   <= S_IDLE;
                    ld_ctrl   <= 2'b00;
                    ld_nibble <= 4'h0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
